// File: rtl/ldpc_ram_arb_if.sv
// Request/grant bus between the LDPC RAM clients, the arbiter and the shared RAM port.
// The arbiter connects through the slave modport; the clients and RAM use master/mem.
interface ldpc_ram_arb_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 7
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic [1:0]        rd_req;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [1:0]        rd_gnt;
    logic              rd_valid;
    logic              rd_id;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr0, rd_addr1, ram_dout,
        output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, ram_addr, ram_wren, ram_din
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr0, rd_addr1,
        input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data
    );

    modport mem (
        input  ram_addr, ram_wren, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ldpc_ram_arb.sv
// Shares one single-port LDPC RAM between a writer and two readers, one access per cycle,
// with tagged read return and blocking of reads that would race the RAM's delayed write.
module ldpc_ram_arb #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 7,
    parameter int unsigned WR_PRIO  = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic               clk,
    input logic               reset,
    ldpc_ram_arb_if.slave     bus
);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {GntNone, GntRd0, GntRd1, GntWr} gnt_e;

    logic              r_last_wr_valid;
    logic [ADDR_W-1:0] r_last_wr_addr;
    logic              r_rr_ptr;
    logic [3:0]        r_wait_cnt;
    logic              r_rd_valid;
    logic              r_rd_id;

    logic [1:0] w_elig;
    logic       w_any_elig;
    logic       w_rd_pick;
    logic       w_wr_win;
    logic       w_rd_gnt;
    gnt_e       w_gnt;

    always_comb begin
        // The RAM commits a write one edge late, so a read of that address must wait a cycle.
        w_elig[0]  = bus.rd_req[0] & ~(r_last_wr_valid & (bus.rd_addr0 == r_last_wr_addr));
        w_elig[1]  = bus.rd_req[1] & ~(r_last_wr_valid & (bus.rd_addr1 == r_last_wr_addr));
        w_any_elig = |w_elig;
        w_rd_pick  = (&w_elig) ? r_rr_ptr : w_elig[1];

        if (WR_PRIO != 0) begin
            w_wr_win = bus.wr_req & ~(w_any_elig & (r_wait_cnt == MaxWait));
        end else begin
            w_wr_win = bus.wr_req & ~w_any_elig;
        end

        w_gnt = GntNone;
        if (!reset) begin
            if (w_wr_win) begin
                w_gnt = GntWr;
            end else if (w_any_elig) begin
                w_gnt = w_rd_pick ? GntRd1 : GntRd0;
            end
        end
        w_rd_gnt = (w_gnt == GntRd0) || (w_gnt == GntRd1);
    end

    always_comb begin
        bus.wr_gnt   = 1'b0;
        bus.rd_gnt   = 2'b00;
        bus.ram_addr = '0;
        bus.ram_wren = 1'b0;
        bus.ram_din  = {DATA_W{1'b0}};
        unique case (w_gnt)
            GntWr: begin
                bus.wr_gnt   = 1'b1;
                bus.ram_addr = bus.wr_addr;
                bus.ram_din  = bus.wr_data;
                bus.ram_wren = 1'b1;
            end
            GntRd0: begin
                bus.rd_gnt   = 2'b01;
                bus.ram_addr = bus.rd_addr0;
            end
            GntRd1: begin
                bus.rd_gnt   = 2'b10;
                bus.ram_addr = bus.rd_addr1;
            end
            default: ;
        endcase
        bus.rd_valid = r_rd_valid;
        bus.rd_id    = r_rd_id;
        bus.rd_data  = bus.ram_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_wr_valid <= 1'b0;
            r_last_wr_addr  <= '0;
            r_rr_ptr        <= 1'b0;
            r_wait_cnt      <= 4'd0;
            r_rd_valid      <= 1'b0;
            r_rd_id         <= 1'b0;
        end else begin
            r_last_wr_valid <= (w_gnt == GntWr);
            r_last_wr_addr  <= bus.wr_addr;
            r_rd_valid      <= w_rd_gnt;
            r_rd_id         <= (w_gnt == GntRd1);
            if (w_rd_gnt) begin
                r_rr_ptr   <= (w_gnt == GntRd0);
                r_wait_cnt <= 4'd0;
            end else if ((w_gnt == GntWr) && w_any_elig && (r_wait_cnt != MaxWait)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ldpc_ram_arb.sv
// Bench for ldpc_ram_arb: a writer-priority and a reader-priority instance, each on its own
// RAM model, checked every cycle against a rule-level model plus directed scenario checks.
module tb_ldpc_ram_arb;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 7;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldpc_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    ldpc_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    ldpc_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .WR_PRIO(1), .MAX_WAIT(MW)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0)
    );
    ldpc_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .WR_PRIO(0), .MAX_WAIT(MW)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1)
    );

    // Stimulus, per instance
    logic          s_wr_req  [2];
    logic [AW-1:0] s_wr_addr [2];
    logic [DW-1:0] s_wr_data [2];
    logic [1:0]    s_rd_req  [2];
    logic [AW-1:0] s_a0      [2];
    logic [AW-1:0] s_a1      [2];

    assign bus0.wr_req   = s_wr_req[0];
    assign bus0.wr_addr  = s_wr_addr[0];
    assign bus0.wr_data  = s_wr_data[0];
    assign bus0.rd_req   = s_rd_req[0];
    assign bus0.rd_addr0 = s_a0[0];
    assign bus0.rd_addr1 = s_a1[0];
    assign bus1.wr_req   = s_wr_req[1];
    assign bus1.wr_addr  = s_wr_addr[1];
    assign bus1.wr_data  = s_wr_data[1];
    assign bus1.rd_req   = s_rd_req[1];
    assign bus1.rd_addr0 = s_a0[1];
    assign bus1.rd_addr1 = s_a1[1];

    // Observed outputs
    logic          o_wgnt  [2];
    logic [1:0]    o_rgnt  [2];
    logic [AW-1:0] o_raddr [2];
    logic          o_wren  [2];
    logic [DW-1:0] o_din   [2];
    logic          o_rv    [2];
    logic          o_rid   [2];
    logic [DW-1:0] o_rdata [2];

    assign o_wgnt[0]  = bus0.wr_gnt;
    assign o_rgnt[0]  = bus0.rd_gnt;
    assign o_raddr[0] = bus0.ram_addr;
    assign o_wren[0]  = bus0.ram_wren;
    assign o_din[0]   = bus0.ram_din;
    assign o_rv[0]    = bus0.rd_valid;
    assign o_rid[0]   = bus0.rd_id;
    assign o_rdata[0] = bus0.rd_data;
    assign o_wgnt[1]  = bus1.wr_gnt;
    assign o_rgnt[1]  = bus1.rd_gnt;
    assign o_raddr[1] = bus1.ram_addr;
    assign o_wren[1]  = bus1.ram_wren;
    assign o_din[1]   = bus1.ram_din;
    assign o_rv[1]    = bus1.rd_valid;
    assign o_rid[1]   = bus1.rd_id;
    assign o_rdata[1] = bus1.rd_data;

    // RAM models: 1-cycle read latency, write committed one edge after it is presented
    logic [DW-1:0] mem   [2][256] = '{default: '0};
    logic          pw_we [2] = '{1'b0, 1'b0};
    logic [AW-1:0] pw_a  [2];
    logic [DW-1:0] pw_d  [2];
    logic [DW-1:0] dout  [2];

    assign bus0.ram_dout = dout[0];
    assign bus1.ram_dout = dout[1];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pw_we[d]) mem[d][pw_a[d]] <= pw_d[d];
            pw_we[d] <= o_wren[d];
            pw_a[d]  <= o_raddr[d];
            pw_d[d]  <= o_din[d];
            dout[d]  <= mem[d][o_raddr[d]];
        end
    end

    // Reference model state: architectural memory plus the arbitration bookkeeping
    logic [DW-1:0] shadow [2][256];
    bit            m_lwv  [2];
    logic [AW-1:0] m_lwa  [2];
    int            m_pref [2];
    int            m_blk  [2];
    bit            m_rv   [2];
    int            m_rid  [2];
    logic [DW-1:0] m_rdata[2];
    int            cur_w  [2];
    int            cur_rdw[2];

    // Snapshots of the outputs taken at the last sample point
    logic          sn_wgnt [2];
    logic [1:0]    sn_rgnt [2];
    logic          sn_wren [2];
    logic          sn_rv   [2];
    logic          sn_rid  [2];
    logic [DW-1:0] sn_rdata[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic int rd_choice(input int d);
        bit e0, e1;
        e0 = s_rd_req[d][0] && !(m_lwv[d] && (s_a0[d] == m_lwa[d]));
        e1 = s_rd_req[d][1] && !(m_lwv[d] && (s_a1[d] == m_lwa[d]));
        if (e0 && e1) return m_pref[d];
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    // Returns -1 none, 0/1 reader, 2 writer. Instance 0 is writer-priority.
    function automatic int winner(input int d);
        int r;
        r = rd_choice(d);
        if (rst) return -1;
        if (d == 0) begin
            if (s_wr_req[d] && !(r >= 0 && m_blk[d] >= MW)) return 2;
            return r;
        end
        if (r >= 0) return r;
        if (s_wr_req[d]) return 2;
        return -1;
    endfunction

    task automatic model_update(input int d);
        int w;
        w = cur_w[d];
        if (rst) begin
            m_lwv[d]  = 1'b0;
            m_pref[d] = 0;
            m_blk[d]  = 0;
            m_rv[d]   = 1'b0;
            m_rid[d]  = 0;
        end else begin
            m_lwv[d] = (w == 2);
            m_lwa[d] = s_wr_addr[d];
            m_rv[d]  = (w == 0 || w == 1);
            if (w == 0 || w == 1) begin
                m_rid[d]   = w;
                m_rdata[d] = shadow[d][(w == 0) ? s_a0[d] : s_a1[d]];
                m_pref[d]  = 1 - w;
                m_blk[d]   = 0;
            end else if (w == 2 && cur_rdw[d] >= 0 && m_blk[d] < MW) begin
                m_blk[d]++;
            end
            if (w == 2) shadow[d][s_wr_addr[d]] = s_wr_data[d];
        end
    endtask

    // One clock: check both instances mid-cycle, then advance the model past the edge.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w;
            w = winner(d);
            cur_w[d]   = w;
            cur_rdw[d] = rd_choice(d);
            chk("wr_gnt", d, o_wgnt[d], (w == 2) ? 1 : 0);
            chk("rd_gnt", d, o_rgnt[d], (w == 0) ? 1 : (w == 1) ? 2 : 0);
            chk("ram_addr", d, o_raddr[d],
                (w == 2) ? s_wr_addr[d] : (w == 0) ? s_a0[d] : (w == 1) ? s_a1[d] : 0);
            chk("ram_wren", d, o_wren[d], (w == 2) ? 1 : 0);
            chk("ram_din", d, o_din[d], (w == 2) ? s_wr_data[d] : 0);
            chk("rd_valid", d, o_rv[d], m_rv[d]);
            if (m_rv[d]) begin
                chk("rd_id", d, o_rid[d], m_rid[d]);
                chk("rd_data", d, o_rdata[d], m_rdata[d]);
            end
            sn_wgnt[d]  = o_wgnt[d];
            sn_rgnt[d]  = o_rgnt[d];
            sn_wren[d]  = o_wren[d];
            sn_rv[d]    = o_rv[d];
            sn_rid[d]   = o_rid[d];
            sn_rdata[d] = o_rdata[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d);
        #1;
    endtask

    task automatic set_all(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic [1:0] rq, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1);
        for (int d = 0; d < 2; d++) begin
            s_wr_req[d]  = wr;
            s_wr_addr[d] = wa;
            s_wr_data[d] = wd;
            s_rd_req[d]  = rq;
            s_a0[d]      = a0;
            s_a1[d]      = a1;
        end
    endtask

    initial begin
        bit prev_rst;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) shadow[d][a] = '0;
            m_lwv[d]  = 1'b0;
            m_lwa[d]  = '0;
            m_pref[d] = 0;
            m_blk[d]  = 0;
            m_rv[d]   = 1'b0;
            m_rid[d]  = 0;
            m_rdata[d] = '0;
        end

        // Reset with every requester active
        set_all(1'b1, 8'h01, 7'h11, 2'b11, 8'h02, 8'h03);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        repeat (3) begin
            tick();
            chk("rst_wr_gnt", 0, sn_wgnt[0], 0);
            chk("rst_rd_gnt", 0, sn_rgnt[0], 0);
            chk("rst_wren", 0, sn_wren[0], 0);
        end
        rst = 1'b0;
        tick();
        chk("rel_wr_gnt", 0, sn_wgnt[0], 1);
        chk("rel_rd_valid", 0, sn_rv[0], 0);
        chk("rel_rd_gnt", 1, sn_rgnt[1], 2'b01);

        // Round-robin between two continuous readers
        set_all(1'b0, 8'h00, 7'h00, 2'b11, 8'h40, 8'h41);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", 0, sn_rgnt[0], (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("rr_valid", 0, sn_rv[0], 1);
                chk("rr_id", 0, sn_rid[0], (i - 1) % 2);
            end
        end

        // Write 0x55 to 0x12 then read it back through the hazard window
        set_all(1'b1, 8'h12, 7'h55, 2'b00, 8'h00, 8'h00);
        tick();
        for (int d = 0; d < 2; d++) chk("hz_wr", d, sn_wgnt[d], 1);
        set_all(1'b0, 8'h00, 7'h00, 2'b01, 8'h12, 8'h00);
        tick();
        for (int d = 0; d < 2; d++) chk("hz_block", d, sn_rgnt[d], 2'b00);
        tick();
        for (int d = 0; d < 2; d++) chk("hz_gnt", d, sn_rgnt[d], 2'b01);
        set_all(1'b0, 8'h00, 7'h00, 2'b00, 8'h00, 8'h00);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("hz_valid", d, sn_rv[d], 1);
            chk("hz_id", d, sn_rid[d], 0);
            chk("hz_data", d, sn_rdata[d], 7'h55);
        end

        // Reader 1 blocked by a continuous writer is forced through after MAX_WAIT cycles
        for (int i = 0; i < 7; i++) begin
            set_all(1'b1, 8'(8'h80 + i), 7'(i), (i == 5) ? 2'b00 : 2'b10, 8'h00, 8'h30);
            tick();
            if (i < MW) begin
                chk("sv_wr", 0, sn_wgnt[0], 1);
            end else if (i == MW) begin
                chk("sv_rd", 0, sn_rgnt[0], 2'b10);
                chk("sv_wr_lost", 0, sn_wgnt[0], 0);
            end else begin
                chk("sv_wr_after", 0, sn_wgnt[0], 1);
            end
        end

        // Reader-priority instance: writer waits until both readers drop
        set_all(1'b1, 8'h90, 7'h09, 2'b11, 8'h91, 8'h92);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("p0_wr", 1, sn_wgnt[1], 0);
            chk("p0_alt", 1, sn_rgnt[1], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        set_all(1'b1, 8'h90, 7'h09, 2'b00, 8'h00, 8'h00);
        tick();
        chk("p0_wr_free", 1, sn_wgnt[1], 1);

        // Reset during a read's return cycle drops the return and rewinds round-robin
        set_all(1'b0, 8'h00, 7'h00, 2'b01, 8'h12, 8'h00);
        tick();
        for (int d = 0; d < 2; d++) chk("mr_gnt", d, sn_rgnt[d], 2'b01);
        set_all(1'b0, 8'h00, 7'h00, 2'b00, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) chk("mr_no_stale", d, sn_rv[d], 0);
        set_all(1'b0, 8'h00, 7'h00, 2'b11, 8'h20, 8'h21);
        tick();
        for (int d = 0; d < 2; d++) chk("mr_rr", d, sn_rgnt[d], 2'b01);
        set_all(1'b0, 8'h00, 7'h00, 2'b00, 8'h00, 8'h00);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("mr_valid", d, sn_rv[d], 1);
            chk("mr_id", d, sn_rid[d], 0);
        end

        // Randomised traffic over a small address range to provoke hazards
        prev_rst = 1'b0;
        repeat (800) begin
            rst = ($urandom_range(63) == 0);
            for (int d = 0; d < 2; d++) begin
                s_wr_req[d]  = ($urandom_range(2) != 0);
                s_wr_addr[d] = AW'($urandom_range(7));
                s_wr_data[d] = DW'($urandom);
                for (int k = 0; k < 2; k++) begin
                    if (s_rd_req[d][k] && !sn_rgnt[d][k] && !prev_rst) begin
                        if ($urandom_range(3) == 0) begin
                            if (k == 0) s_a0[d] = AW'($urandom_range(7));
                            else        s_a1[d] = AW'($urandom_range(7));
                        end
                    end else begin
                        s_rd_req[d][k] = 1'($urandom_range(1));
                        if (k == 0) s_a0[d] = AW'($urandom_range(7));
                        else        s_a1[d] = AW'($urandom_range(7));
                    end
                end
            end
            prev_rst = rst;
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
